// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the Uart command responder.
// Holds the command/response byte constants, the responder FSM state
// encoding, the read/write mode encoding and the transmit handshake phases.
// Optional feature macro used elsewhere: UART_RESP_TIMEOUT_EN.
package uart_cmd_pkg;

  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] ACK_BYTE = 8'h4B;  // 'K'
  localparam logic [7:0] NAK_BYTE = 8'h3F;  // '?'

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 50_000_000;
  localparam int          GAP_W                  = 26;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    BUS_WR,
    BUS_RD,
    BUS_WAIT,
    TX_REQ,
    TX_BUSY
  } state_t;

  typedef enum logic {
    MODE_RD = 1'b0,
    MODE_WR = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_REQ,
    HS_BUSY
  } hs_state_t;

endpackage

// File: rtl/uart_tx_handshake.sv
// Request-hold-until-accepted transmit handshake toward the Uart.
// The Uart only samples write_enable on its baud slice boundary, so the
// request is held (with tx_data stable) until tx_ready is seen low, then the
// block waits for the transmitter to go idle again.
// Ports:
//   clock, reset  - system clock, asynchronous active-high reset
//   start, data   - one-cycle start pulse and the byte to send
//   tx_ready      - Uart transmitter idle
//   tx_data       - byte presented to the Uart
//   write_enable  - held transmit request
//   accepted      - pulse: Uart took the request (tx_ready went low)
//   done          - pulse: transmitter idle again, frame finished
module uart_tx_handshake
  import uart_cmd_pkg::*;
  (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       write_enable,
    output logic       accepted,
    output logic       done
  );

  hs_state_t state, next_state;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= HS_IDLE;
      tx_data <= '0;
    end else begin
      state <= next_state;
      if (start && state == HS_IDLE) tx_data <= data;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    next_state   = state;
    write_enable = 1'b0;
    accepted     = 1'b0;
    done         = 1'b0;
    case (state)
      HS_IDLE: if (start) next_state = HS_REQ;
      HS_REQ: begin
        write_enable = 1'b1;
        if (!tx_ready) begin
          accepted   = 1'b1;
          next_state = HS_BUSY;
        end
      end
      HS_BUSY: begin
        if (tx_ready) begin
          done       = 1'b1;
          next_state = HS_IDLE;
        end
      end
      default: next_state = HS_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Byte-level command responder behind a Uart byte interface.
// Commands: 'R' addr -> reply with register byte; 'W' addr data -> register
// write, reply 'K'; any other opcode -> reply '?'. Bytes arriving while a
// command is executing or its reply is in flight are dropped.
// Optional feature: define UART_RESP_TIMEOUT_EN to abandon a partial command
// after TIMEOUT_CYCLES idle cycles between its bytes (no reply, no bus access).
// Ports:
//   clock, reset                 - system clock, asynchronous active-high reset
//   uart_rx_data, uart_rx_ready  - received byte and its level ready flag
//   uart_tx_data, uart_write_enable, uart_tx_ready - transmit handshake
//   bus_addr, bus_wdata, bus_we, bus_re, bus_rdata  - register bus, 1-cycle read latency
//   busy                         - high whenever a command is in progress
module uart_cmd_responder
  import uart_cmd_pkg::*;
  #(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
  )
  (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] uart_rx_data,
    input  logic       uart_rx_ready,
    output logic [7:0] uart_tx_data,
    output logic       uart_write_enable,
    input  logic       uart_tx_ready,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_we,
    output logic       bus_re,
    input  logic [7:0] bus_rdata,
    output logic       busy
  );

  state_t     state, next_state;
  mode_t      mode;
  logic       rx_ready_q;
  logic       byte_strb;
  logic       gap_expired;
  logic       hs_start;
  logic [7:0] hs_byte;
  logic       hs_accepted;
  logic       hs_done;

  // rx_ready is a level; a new byte is its rising edge. The history flop
  // resets high so a level already present at reset is not a new byte.
  assign byte_strb = uart_rx_ready & ~rx_ready_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rx_ready_q <= 1'b1;
      mode       <= MODE_RD;
      bus_addr   <= '0;
      bus_wdata  <= '0;
    end else begin
      state      <= next_state;
      rx_ready_q <= uart_rx_ready;
      if (byte_strb) begin
        case (state)
          IDLE:     mode      <= (uart_rx_data == OP_WRITE) ? MODE_WR : MODE_RD;
          GET_ADDR: bus_addr  <= uart_rx_data;
          GET_DATA: bus_wdata <= uart_rx_data;
          default: ;
        endcase
      end
    end
  end

`ifdef UART_RESP_TIMEOUT_EN
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
  logic [GAP_W-1:0] gap_cnt;

  // Counts idle cycles only while waiting for the next byte of a command.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (byte_strb || !(state == GET_ADDR || state == GET_DATA)) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

  assign gap_expired = (gap_cnt == GAP_LAST);
`else
  assign gap_expired = 1'b0;
`endif

  always_comb begin
    next_state = state;
    hs_start   = 1'b0;
    hs_byte    = NAK_BYTE;
    bus_we     = (state == BUS_WR);
    bus_re     = (state == BUS_RD);
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (byte_strb) begin
          if (uart_rx_data == OP_READ || uart_rx_data == OP_WRITE) begin
            next_state = GET_ADDR;
          end else begin
            hs_start   = 1'b1;
            next_state = TX_REQ;
          end
        end
      end
      GET_ADDR: begin
        if (byte_strb)        next_state = (mode == MODE_RD) ? BUS_RD : GET_DATA;
        else if (gap_expired) next_state = IDLE;
      end
      GET_DATA: begin
        if (byte_strb)        next_state = BUS_WR;
        else if (gap_expired) next_state = IDLE;
      end
      BUS_WR: begin
        hs_start   = 1'b1;
        hs_byte    = ACK_BYTE;
        next_state = TX_REQ;
      end
      BUS_RD: next_state = BUS_WAIT;
      BUS_WAIT: begin
        // Read data is valid exactly one cycle after bus_re.
        hs_start   = 1'b1;
        hs_byte    = bus_rdata;
        next_state = TX_REQ;
      end
      TX_REQ:  if (hs_accepted) next_state = TX_BUSY;
      TX_BUSY: if (hs_done)     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  uart_tx_handshake u_tx (
    .clock        (clock),
    .reset        (reset),
    .start        (hs_start),
    .data         (hs_byte),
    .tx_ready     (uart_tx_ready),
    .tx_data      (uart_tx_data),
    .write_enable (uart_write_enable),
    .accepted     (hs_accepted),
    .done         (hs_done)
  );

endmodule
